// File: rtl/add64_sequencer.sv
// add64_sequencer: multi-word unsigned adder that steps one 16-bit adder through the operand words, LSB word first,
// with a carry register chaining the words together.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module add64_sequencer #(
  parameter  int NUM_WORDS = 4,
  localparam int W  = 16 * NUM_WORDS,
  localparam int IW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         overflow
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0]  r_op_a, r_op_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [15:0]   w_a_word, w_b_word, w_sum_word;
  logic          w_cout, w_last;
  assign w_a_word = r_op_a[16*r_idx +: 16];
  assign w_b_word = r_op_b[16*r_idx +: 16];
  assign w_last   = r_idx == IW'(NUM_WORDS - 1);
  assign busy     = r_state == ADD;
  assign done     = r_state == DONE;
  adder_16bit u_add (
    .a(w_a_word),
    .b(w_b_word),
    .cin(r_carry),
    .sum(w_sum_word),
    .overflow(w_cout)
  );
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ADD : IDLE;
      ADD:     w_next = w_last ? DONE : ADD;
      default: w_next = IDLE;
    endcase
  end
  // Operand registers need no reset: they are always loaded before ADD reads them.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_op_a  <= a;
      r_op_b  <= b;
      r_carry <= carry_in;
      r_idx   <= '0;
    end else if (r_state == ADD) begin
      sum[16*r_idx +: 16] <= w_sum_word;
      r_carry             <= w_cout;
      if (w_last) overflow <= w_cout;
      else        r_idx    <= r_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_add64_sequencer.sv
// tb_add64_sequencer: checks the sequencer against a plain 65-bit a+b+carry_in reference.
module tb_add64_sequencer;
  localparam int NW = 4;
  localparam int W  = 16 * NW;
  logic         clk = 1'b0;
  logic         n_rst, start, carry_in;
  logic [W-1:0] a, b;
  logic         busy, done, overflow;
  logic [W-1:0] sum;
  int checks = 0;
  int passed = 0;

  add64_sequencer #(.NUM_WORDS(NW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Launch one operation and watch the following NW+2 cycles; optionally disturb inputs mid-flight.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit disturb,
                       output int busy_cnt, output int done_cnt, output int done_pos,
                       output logic [W-1:0] s, output logic ov);
    a = x; b = y; carry_in = c; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_pos = -1; s = 'x; ov = 1'bx;
    for (int p = 0; p < NW + 2; p++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_pos = p; s = sum; ov = overflow; end
      if (disturb && p < 3) begin
        start = (p < 2);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; carry_in = $urandom_range(0, 1);
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; carry_in = 1'b1;
    tick(); tick();
    checks++; if ({busy, done, overflow, sum} !== '0) $display("FAIL reset_outputs busy=%b done=%b ovf=%b sum=%h want all 0", busy, done, overflow, sum); else passed++;
    start = 1'b0; n_rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_no_start busy=%b done=%b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int bc, dc, dp; logic [W-1:0] s; logic ov; logic [W:0] e;
    e = ref_add(x, y, c);
    do_op(x, y, c, 1'b0, bc, dc, dp, s, ov);
    checks++; if (bc !== NW) $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, NW); else passed++;
    checks++; if (dc !== 1 || dp !== NW) $display("FAIL %s_done_pulse count=%0d pos=%0d want 1 at %0d", name, dc, dp, NW); else passed++;
    checks++; if ({ov, s} !== e) $display("FAIL %s_result got %b_%h want %b_%h", name, ov, s, e[W], e[W-1:0]); else passed++;
  endtask

  task automatic test_protocol();
    int bc, dc, dp; logic [W-1:0] s, x, y; logic ov, c; logic [W:0] e;
    x = {$urandom, $urandom}; y = {$urandom, $urandom}; c = 1'b1; e = ref_add(x, y, c);
    do_op(x, y, c, 1'b1, bc, dc, dp, s, ov);
    checks++; if (dc !== 1 || dp !== NW) $display("FAIL protocol_done count=%0d pos=%0d want 1 at %0d", dc, dp, NW); else passed++;
    checks++; if ({ov, s} !== e) $display("FAIL protocol_captured got %b_%h want %b_%h", ov, s, e[W], e[W-1:0]); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL protocol_no_relaunch busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int dpos[$]; int bpos[$]; logic [W:0] e; logic bad_sum;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; carry_in = 1'b0; e = ref_add(a, b, 1'b0);
    start = 1'b1; bad_sum = 1'b0;
    tick();
    for (int p = 0; p < 3 * (NW + 2); p++) begin
      if (busy && (p == 0 || bpos.size() == 0 || bpos[$] != p - 1)) bpos.push_back(p);
      if (busy) bpos[$] = p;
      if (done) begin dpos.push_back(p); if ({overflow, sum} !== e) bad_sum = 1'b1; end
      if (p == 2 * (NW + 2) - 2) start = 1'b0;
      tick();
    end
    checks++; if (dpos.size() !== 2) $display("FAIL b2b_done_count got %0d want 2", dpos.size()); else passed++;
    checks++; if (dpos.size() == 2 && dpos[1] - dpos[0] !== NW + 2) $display("FAIL b2b_spacing got %0d want %0d", dpos[1] - dpos[0], NW + 2); else passed++;
    checks++; if (bad_sum) $display("FAIL b2b_result bad sum at a done pulse want %h", e); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int dc = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; carry_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else passed++;
    n_rst = 1'b0;
    tick();
    checks++; if ({busy, done, overflow, sum} !== '0) $display("FAIL midrst_outputs busy=%b done=%b ovf=%b sum=%h want all 0", busy, done, overflow, sum); else passed++;
    n_rst = 1'b1;
    for (int p = 0; p < NW + 3; p++) begin
      if (done) dc++;
      tick();
    end
    checks++; if (dc !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", dc); else passed++;
  endtask

  task automatic test_random();
    int bad = 0; int bc, dc, dp; logic [W-1:0] s, x, y; logic ov, c; logic [W:0] e;
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; c = $urandom_range(0, 1);
      if (i % 10 == 0) x = '1;
      e = ref_add(x, y, c);
      do_op(x, y, c, 1'b0, bc, dc, dp, s, ov);
      checks++;
      if (dc !== 1 || dp !== NW || {ov, s} !== e) begin
        bad++;
        if (bad <= 5) $display("FAIL random_%0d got %b_%h done=%0d@%0d want %b_%h", i, ov, s, dc, dp, e[W], e[W-1:0]);
      end else passed++;
    end
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    test_reset();
    test_vector("basic", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0);
    test_vector("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    test_vector("word_carry", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    test_protocol();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
